tx_fcs_inserter: RTL

//  TX MAC sequencer for the 4-byte-slice crc32 engine (configured INVERT_OUTPUT=1, REGISTER_OUTPUT=1).

---
 rtl/tx_fcs_inserter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tx_fcs_inserter.sv
// TX MAC frame sequencer: forwards payload beats to the PCS path while feeding a crc32 slice
// engine, zero-pads short frames to MIN_FRAME_BYTES and appends the 4-byte FCS.
module tx_fcs_inserter #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int CNT_WIDTH       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_keep,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        crc_clear,
  output logic [31:0] crc_data,
  output logic [3:0]  crc_valid,
  input  logic [31:0] crc_value
);

  typedef enum logic [2:0] {CLR, DATA, PAD, MERGE, FCS, TAIL} state_t;

  localparam logic [CNT_WIDTH:0] MIN_W = (CNT_WIDTH+1)'(MIN_FRAME_BYTES);

  state_t              state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [31:0]         hold_data_reg, hold_data_next;
  logic [3:0]          hold_keep_reg, hold_keep_next;
  logic [31:0]         out_data_next;
  logic [3:0]          out_keep_next;
  logic                out_valid_next, out_last_next;

  logic                out_free, accept;
  logic [31:0]         in_masked;
  logic [2:0]          keep_cnt;
  logic [CNT_WIDTH:0]  total, total_up, cnt_plus4;
  logic [CNT_WIDTH-1:0] cnt_sat;
  logic [31:0]         merge_data, tail_data;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign in_masked[8*gi +: 8] = in_data[8*gi +: 8] & {8{in_keep[gi]}};
    end
  endgenerate

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign keep_cnt = 3'(in_keep[0]) + 3'(in_keep[1]) + 3'(in_keep[2]) + 3'(in_keep[3]);
  assign total    = {1'b0, cnt_reg} + {{(CNT_WIDTH-2){1'b0}}, keep_cnt};
  // Short frames always end on a 4-byte boundary once zero-filled.
  assign total_up  = (total + (CNT_WIDTH+1)'(3)) & ~(CNT_WIDTH+1)'(3);
  assign cnt_sat   = (total >= MIN_W) ? MIN_W[CNT_WIDTH-1:0] : total[CNT_WIDTH-1:0];
  assign cnt_plus4 = {1'b0, cnt_reg} + (CNT_WIDTH+1)'(4);

  // Split the FCS around the k held tail bytes: low FCS bytes fill the merge beat.
  always_comb begin
    case (hold_keep_reg)
      4'b0001: begin
        merge_data = {crc_value[23:0], hold_data_reg[7:0]};
        tail_data  = {24'd0, crc_value[31:24]};
      end
      4'b0011: begin
        merge_data = {crc_value[15:0], hold_data_reg[15:0]};
        tail_data  = {16'd0, crc_value[31:16]};
      end
      default: begin
        merge_data = {crc_value[7:0], hold_data_reg[23:0]};
        tail_data  = {8'd0, crc_value[31:8]};
      end
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hold_data_next = hold_data_reg;
    hold_keep_next = hold_keep_reg;
    out_data_next  = out_data;
    out_keep_next  = out_keep;
    out_last_next  = out_last;
    out_valid_next = out_free ? 1'b0 : out_valid;
    in_ready       = 1'b0;
    crc_clear      = 1'b0;
    crc_data       = 32'd0;
    crc_valid      = 4'd0;

    case (state_reg)
      CLR: begin
        crc_clear = 1'b1;
        cnt_next  = '0;
        if (out_free) state_next = DATA;
      end

      DATA: begin
        in_ready = out_free;
        if (accept) begin
          crc_data = in_masked;
          if (!in_last) begin
            crc_valid      = in_keep;
            out_data_next  = in_masked;
            out_keep_next  = in_keep;
            out_last_next  = 1'b0;
            out_valid_next = 1'b1;
            cnt_next       = cnt_sat;
          end else if (total < MIN_W) begin
            crc_valid      = 4'hF;
            out_data_next  = in_masked;
            out_keep_next  = 4'hF;
            out_last_next  = 1'b0;
            out_valid_next = 1'b1;
            cnt_next       = total_up[CNT_WIDTH-1:0];
            state_next     = (total_up == MIN_W) ? FCS : PAD;
          end else if (in_keep == 4'hF) begin
            crc_valid      = 4'hF;
            out_data_next  = in_masked;
            out_keep_next  = 4'hF;
            out_last_next  = 1'b0;
            out_valid_next = 1'b1;
            cnt_next       = cnt_sat;
            state_next     = FCS;
          end else begin
            crc_valid      = in_keep;
            hold_data_next = in_masked;
            hold_keep_next = in_keep;
            cnt_next       = cnt_sat;
            state_next     = MERGE;
          end
        end
      end

      PAD: begin
        if (out_free) begin
          crc_valid      = 4'hF;
          out_data_next  = 32'd0;
          out_keep_next  = 4'hF;
          out_last_next  = 1'b0;
          out_valid_next = 1'b1;
          cnt_next       = cnt_plus4[CNT_WIDTH-1:0];
          if (cnt_plus4 == MIN_W) state_next = FCS;
        end
      end

      FCS: begin
        if (out_free) begin
          out_data_next  = crc_value;
          out_keep_next  = 4'hF;
          out_last_next  = 1'b1;
          out_valid_next = 1'b1;
          state_next     = CLR;
        end
      end

      MERGE: begin
        if (out_free) begin
          out_data_next  = merge_data;
          out_keep_next  = 4'hF;
          out_last_next  = 1'b0;
          out_valid_next = 1'b1;
          state_next     = TAIL;
        end
      end

      TAIL: begin
        if (out_free) begin
          out_data_next  = tail_data;
          out_keep_next  = hold_keep_reg;
          out_last_next  = 1'b1;
          out_valid_next = 1'b1;
          state_next     = CLR;
        end
      end

      default: state_next = CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= CLR;
      cnt_reg       <= '0;
      hold_data_reg <= 32'd0;
      hold_keep_reg <= 4'd0;
      out_data      <= 32'd0;
      out_keep      <= 4'd0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hold_data_reg <= hold_data_next;
      hold_keep_reg <= hold_keep_next;
      out_data      <= out_data_next;
      out_keep      <= out_keep_next;
      out_valid     <= out_valid_next;
      out_last      <= out_last_next;
    end
  end

endmodule
